// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the two-digit multiplexed seven-segment interface.
// Holds the active-low glyph encoding used by both the display driver
// (encoder side) and the capture block (decoder side), the capture FSM state
// type, the packed view of the nine scanned lines, and the glyph decoder.
//
// Segment vector ordering is {ca,cb,cc,cd,ce,cf,cg}; a 0 lights a segment.
// ---------------------------------------------------------------------------
package sseg_pkg;

    localparam int SEG_W = 7;

    // Active-low glyphs for the sixteen hex digits.
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'b0000001;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'b1001111;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'b0010010;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'b0000110;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'b1001100;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'b0100100;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'b0100000;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'b0001111;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'b0000000;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'b0000100;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'b0001000;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'b1100000;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'b0110001;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'b1000010;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'b0110000;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'b0111000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } cap_state_t;

    // The nine scanned lines as seen by the capture logic.
    typedef struct packed {
        logic             an1;
        logic             an0;
        logic [SEG_W-1:0] seg;
    } lines_t;

    // Everything off: both anodes high, all segments dark.
    localparam lines_t LINES_IDLE = '{an1: 1'b1, an0: 1'b1, seg: '1};

    // Returns {ok, value}; ok=0 for any pattern that is not a hex glyph.
    function automatic logic [4:0] sseg_decode(input logic [SEG_W-1:0] seg);
        logic [4:0] res;
        res = 5'b0_0000;
        case (seg)
            GLYPH_0: res = {1'b1, 4'h0};
            GLYPH_1: res = {1'b1, 4'h1};
            GLYPH_2: res = {1'b1, 4'h2};
            GLYPH_3: res = {1'b1, 4'h3};
            GLYPH_4: res = {1'b1, 4'h4};
            GLYPH_5: res = {1'b1, 4'h5};
            GLYPH_6: res = {1'b1, 4'h6};
            GLYPH_7: res = {1'b1, 4'h7};
            GLYPH_8: res = {1'b1, 4'h8};
            GLYPH_9: res = {1'b1, 4'h9};
            GLYPH_A: res = {1'b1, 4'hA};
            GLYPH_B: res = {1'b1, 4'hB};
            GLYPH_C: res = {1'b1, 4'hC};
            GLYPH_D: res = {1'b1, 4'hD};
            GLYPH_E: res = {1'b1, 4'hE};
            GLYPH_F: res = {1'b1, 4'hF};
            default: res = 5'b0_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sseg_capture_if.sv
// ---------------------------------------------------------------------------
// sseg_capture_if
// Bundles the scanned display lines and the recovered per-digit results.
//   ca..cg     segment lines, active-low (driven by the display side)
//   AN0, AN1   digit anodes, active-low  (driven by the display side)
//   digit0/1   last accepted hex value per digit
//   valid0/1   digit holds a live accepted value
//   err0/1     last stable pattern on the digit was not a hex glyph
//   upd0/1     one-cycle pulse on each accept
// master: the display driver / stimulus side.  slave: the capture block.
// ---------------------------------------------------------------------------
interface sseg_capture_if;

    logic       ca, cb, cc, cd, ce, cf, cg;
    logic       AN0, AN1;
    logic [3:0] digit0, digit1;
    logic       valid0, valid1;
    logic       err0, err1;
    logic       upd0, upd1;

    modport master (
        output ca, cb, cc, cd, ce, cf, cg, AN0, AN1,
        input  digit0, digit1, valid0, valid1, err0, err1, upd0, upd1
    );

    modport slave (
        input  ca, cb, cc, cd, ce, cf, cg, AN0, AN1,
        output digit0, digit1, valid0, valid1, err0, err1, upd0, upd1
    );

endinterface

// File: rtl/sseg_digit_track.sv
// ---------------------------------------------------------------------------
// sseg_digit_track
// Result holder for one display digit. On commit it either latches a decoded
// hex value (valid glyph) or raises the sticky error flag (bad glyph), and
// pulses upd for one cycle. A saturating age counter clears valid once the
// digit has gone TIMEOUT_CYCLES without a commit; digit and err are held.
// Ports:
//   clk, arst          clock, asynchronous active-low reset
//   commit             accept the current decode on this edge
//   glyph_ok/glyph_val decoder result for the stable pattern
//   digit/valid/err/upd registered results
// ---------------------------------------------------------------------------
module sseg_digit_track #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       commit,
    input  logic       glyph_ok,
    input  logic [3:0] glyph_val,
    output logic [3:0] digit,
    output logic       valid,
    output logic       err,
    output logic       upd
);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]  AGE_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]  AGE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] age;

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            digit <= 4'h0;
            valid <= 1'b0;
            err   <= 1'b0;
            upd   <= 1'b0;
            age   <= '0;
        end else begin
            upd <= commit;
            // A commit beats a timeout landing on the same edge.
            if (commit) begin
                age <= '0;
                if (glyph_ok) begin
                    digit <= glyph_val;
                    valid <= 1'b1;
                    err   <= 1'b0;
                end else begin
                    err   <= 1'b1;
                end
            end else begin
                if (age != AGE_MAX) begin
                    age <= age + 1'b1;
                end
                // Age reaches TIMEOUT_CYCLES on this edge (or already has).
                if (age >= AGE_LAST) begin
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// ---------------------------------------------------------------------------
// sseg_capture
// Receiver for a two-digit multiplexed seven-segment display. The nine scanned
// lines are synchronized, a pattern must stay identical for STABLE_CYCLES
// consecutive samples under a single active anode before it is committed to
// that digit, and each digit tracks its own refresh timeout.
// Ports:
//   clk        system clock
//   arst       asynchronous reset, active-low
//   bus        sseg_capture_if.slave: ca..cg, AN0, AN1 in; digit0/1,
//              valid0/1, err0/1, upd0/1 out
// Latency: a clean pattern present before edge 0 commits on edge
// STABLE_CYCLES+1 (two sync edges, then STABLE_CYCLES samples).
// ---------------------------------------------------------------------------
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         arst,
    sseg_capture_if.slave bus
);

    localparam int            CW         = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

    lines_t        raw;
    lines_t        sync_p1;
    lines_t        s_p2;
    lines_t        s_prev;
    cap_state_t    state;
    logic [CW-1:0] cnt;

    logic          changed;
    logic          an0_on;
    logic          an1_on;
    logic          sel_ok;
    logic          sel;
    logic [CW-1:0] cnt_inc;
    logic          commit_go;
    logic [4:0]    dec;

    assign raw = {bus.AN1, bus.AN0, bus.ca, bus.cb, bus.cc, bus.cd, bus.ce, bus.cf, bus.cg};

    always_comb begin
        changed = (s_p2 != s_prev);
        an0_on  = !s_p2.an0 &&  s_p2.an1;
        an1_on  =  s_p2.an0 && !s_p2.an1;
        sel_ok  = an0_on || an1_on;
        sel     = an1_on;
        // cnt never exceeds STABLE_MAX, and CW has a spare bit, so no wrap.
        cnt_inc = cnt + 1'b1;
        // Commit on the edge where the identical-sample run reaches the target.
        commit_go = !changed && sel_ok && (state != ST_HELD) && (cnt_inc >= STABLE_MAX);
        dec     = sseg_decode(s_p2.seg);
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            sync_p1 <= LINES_IDLE;
            s_p2    <= LINES_IDLE;
            s_prev  <= LINES_IDLE;
            state   <= ST_IDLE;
            cnt     <= '0;
        end else begin
            // Stage p1 -> p2: two-flop synchronizer; s_prev keeps the last sample.
            sync_p1 <= raw;
            s_p2    <= sync_p1;
            s_prev  <= s_p2;
            // Any change or an unusable anode pair restarts the run at 1.
            if (changed || !sel_ok) begin
                state <= ST_IDLE;
                cnt   <= CW'(1);
            end else begin
                case (state)
                    ST_IDLE, ST_COUNT: begin
                        cnt   <= cnt_inc;
                        state <= commit_go ? ST_HELD : ST_COUNT;
                    end
                    ST_HELD: state <= ST_HELD;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    logic [3:0] digit0_w, digit1_w;
    logic       valid0_w, valid1_w, err0_w, err1_w, upd0_w, upd1_w;

    sseg_digit_track #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_trk0 (
        .clk       (clk),
        .arst      (arst),
        .commit    (commit_go && !sel),
        .glyph_ok  (dec[4]),
        .glyph_val (dec[3:0]),
        .digit     (digit0_w),
        .valid     (valid0_w),
        .err       (err0_w),
        .upd       (upd0_w)
    );

    sseg_digit_track #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_trk1 (
        .clk       (clk),
        .arst      (arst),
        .commit    (commit_go && sel),
        .glyph_ok  (dec[4]),
        .glyph_val (dec[3:0]),
        .digit     (digit1_w),
        .valid     (valid1_w),
        .err       (err1_w),
        .upd       (upd1_w)
    );

    assign bus.digit0 = digit0_w;
    assign bus.digit1 = digit1_w;
    assign bus.valid0 = valid0_w;
    assign bus.valid1 = valid1_w;
    assign bus.err0   = err0_w;
    assign bus.err1   = err1_w;
    assign bus.upd0   = upd0_w;
    assign bus.upd1   = upd1_w;

endmodule

// File: doc/sseg_capture.md
Name: sseg_capture

Overview:
- Receiver end of the two-digit multiplexed seven-segment interface: ca..cg plus AN0/AN1, all active-low.
- Samples the scanned display lines and recovers the hex value shown on each digit. Applies stability filtering, flags non-hex patterns and drops validity when a digit stops being refreshed.
- Sits beside the display driver, or in a checker/loopback path, so switch-to-display behaviour can be confirmed in hardware and simulation.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a pattern is accepted (2..255).
- TIMEOUT_CYCLES, 1024: cycles without an accepted pattern on a digit before its valid flag clears (>= 2*STABLE_CYCLES).

Ports:
- clk  input  1  system clock.
- arst  input  1  asynchronous reset, active-low: asserted when 0, released when 1.
- ca,cb,cc,cd,ce,cf,cg  input  1 each  segment lines, active-low.
- AN0, AN1  input  1 each  digit anodes, active-low.
- digit0, digit1  output  4 each  last accepted hex value per digit.
- valid0, valid1  output  1 each  digit has a live, accepted value.
- err0, err1  output  1 each  last stable pattern on that digit was not a hex glyph (sticky until next good accept).
- upd0, upd1  output  1 each  one-cycle pulse on each accept.

Behaviour:
- Reset (arst=0, async): all outputs 0; sync stages cleared to 1 (idle, all off); counters 0; FSM in IDLE.
- Input sync: the 9 lines {AN1,AN0,ca..cg} pass through a 2-flop synchronizer; all logic uses the stage-2 value S.
- Segment vector seg = {ca,cb,cc,cd,ce,cf,cg}. Decode, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000
  - Any other pattern is invalid.
- Select: sel=0 when S.AN0=0 and S.AN1=1; sel=1 when S.AN1=0 and S.AN0=1. Both low or both high = BLANK.
- FSM IDLE:
  - Entered on BLANK or when S differs from the previous S. Stable counter loads 1.
  - Moves to COUNT when the anode select is valid.
- FSM COUNT:
  - Counter increments each cycle S equals the previous S.
  - Any change in S returns to IDLE with counter 1 (a new valid pattern re-enters COUNT next cycle).
  - When the counter reaches STABLE_CYCLES, moves to HELD and commits on that edge.
- FSM HELD: no further commits. Leaves to IDLE on any change of S.
- Commit for digit[sel]:
  - Valid glyph: digit<=value, valid<=1, err<=0, upd pulse 1 cycle.
  - Invalid glyph: digit unchanged, err<=1, valid unchanged, upd pulse 1 cycle.
- Latency: a clean pattern applied before edge 0 is committed at edge STABLE_CYCLES+1. Outputs are visible after edge STABLE_CYCLES+1; default 5 cycles.
- Timeout:
  - Per-digit counter resets to 0 on that digit's commit, otherwise increments and saturates.
  - When it reaches TIMEOUT_CYCLES, valid<=0. digit and err are held.
- Simultaneous events: a commit and a timeout on the same digit in the same cycle resolves to the commit. Only one digit can commit per cycle.
- Reset mid-operation returns everything to reset values immediately. The first commit after release needs the full sync + stability latency.
- Counter width is $clog2 of the parameter + 1; no wrap, saturating.

Decomposition:
- Shared package sseg_pkg holds:
  - SEG_W=7.
  - The 16 glyph constants in the active-low encoding above.
  - A decode function returning {ok, value[3:0]}.
- The display driver uses the same constants as its encoder.
- One natural sub-module, sseg_digit_track, instantiated twice: holds digit/valid/err/upd/timeout for one digit, driven by commit and decode inputs.

Test Plan:
- Reset: hold arst=0 with random inputs -> all outputs 0. Release; apply AN0=0, AN1=1, seg=1001111 -> digit0=1, valid0=1, upd0 one-cycle pulse 5 cycles after application; digit1/valid1 remain 0.
- Alternating scan:
  - AN0 digit=A (0001000) and AN1 digit=3 (0000110), swapped every 8 cycles.
  - Required: digit0=A, digit1=3, both valid, exactly one upd pulse per anode window.
- Glitch rejection:
  - seg=0000001 on AN0 for 3 cycles, then 0010010 held.
  - Required: digit0 never shows 0; it becomes 2 only after the second pattern is stable for 4 samples.
- Invalid glyph: seg=1111110 on AN1 for 10 cycles -> err1=1, digit1 keeps its prior value, upd1 pulses once. Then F (0111000) -> err1=0, digit1=F.
- Timeout and blanking:
  - Commit on AN0, then both anodes high for 1024 cycles -> valid0 falls at exactly 1024 cycles after the commit; digit0 is unchanged.
  - Both anodes low -> no commits.
- Async reset mid-COUNT: arst=0 for 1 cycle, 2 cycles into a stable window -> outputs clear at once; after release the full 5-cycle latency applies again.
